regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_pick.sv | 23 ++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback request type
package regfile_pkg;

  localparam int REG_DATA_W = 16;
  localparam int REG_NUM_W  = 3;
  localparam int REG_COUNT  = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_NUM_W-1:0]  num;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - find-first-set scanning upward from a rotating start index
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[IW'((int'(start) + i) % N)]) begin
        found = 1'b1;
        idx   = IW'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter of N writeback requesters onto two regfile write ports
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int NUM_W  = REG_NUM_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid_in,
  input  logic [NREQ*NUM_W-1:0]  req_num_in,
  input  logic [NREQ*DATA_W-1:0] req_data_in,
  output logic [NREQ-1:0]        req_ready_out,
  output logic                   write0_out,
  output logic                   write1_out,
  output logic [NUM_W-1:0]       num_write0_out,
  output logic [NUM_W-1:0]       num_write1_out,
  output logic [DATA_W-1:0]      data_write0_out,
  output logic [DATA_W-1:0]      data_write1_out,
  output logic [CNT_W-1:0]       conflict_cnt_out
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  rr_ptr, idx0, idx1, last_idx;
  logic              found0, found1;
  logic [NUM_W-1:0]  num_arr  [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [NREQ-1:0]   p1_vec, defer_vec;

  rr_pick #(.N(NREQ), .IW(PTR_W)) u_pick0 (
    .req   (req_valid_in),
    .start (rr_ptr),
    .idx   (idx0),
    .found (found0)
  );

  // Port 1 scans from the same pointer; the port-0 winner and anything
  // targeting its register are masked out, so it lands on the next candidate.
  rr_pick #(.N(NREQ), .IW(PTR_W)) u_pick1 (
    .req   (p1_vec),
    .start (rr_ptr),
    .idx   (idx1),
    .found (found1)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign num_arr[g]  = req_num_in[g*NUM_W +: NUM_W];
    assign data_arr[g] = req_data_in[g*DATA_W +: DATA_W];
    assign p1_vec[g]    = req_valid_in[g] && found0 && (PTR_W'(g) != idx0)
                          && (num_arr[g] != num_arr[idx0]);
    assign defer_vec[g] = req_valid_in[g] && found0 && (PTR_W'(g) != idx0)
                          && (num_arr[g] == num_arr[idx0]);
    assign req_ready_out[g] = !rst && ((found0 && (idx0 == PTR_W'(g)))
                                    || (found1 && (idx1 == PTR_W'(g))));
  end

  assign last_idx = found1 ? idx1 : idx0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write0_out       <= 1'b0;
      write1_out       <= 1'b0;
      num_write0_out   <= '0;
      num_write1_out   <= '0;
      data_write0_out  <= '0;
      data_write1_out  <= '0;
      rr_ptr           <= '0;
      conflict_cnt_out <= '0;
    end else begin
      write0_out <= found0;
      write1_out <= found1;
      if (found0) begin
        num_write0_out  <= num_arr[idx0];
        data_write0_out <= data_arr[idx0];
        rr_ptr <= (last_idx == PTR_W'(NREQ-1)) ? '0 : last_idx + PTR_W'(1);
      end
      if (found1) begin
        num_write1_out  <= num_arr[idx1];
        data_write1_out <= data_arr[idx1];
      end
      if ((|defer_vec) && (conflict_cnt_out != '1))
        conflict_cnt_out <= conflict_cnt_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized bench with a scan-order reference model
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int DW = REG_DATA_W;
  localparam int NW = REG_NUM_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid_in = '0;
  logic [N*NW-1:0] req_num_in = '0;
  logic [N*DW-1:0] req_data_in = '0;
  logic [N-1:0]  req_ready_out;
  logic          write0_out, write1_out;
  logic [NW-1:0] num_write0_out, num_write1_out;
  logic [DW-1:0] data_write0_out, data_write1_out;
  logic [15:0]   conflict_cnt_out;

  logic [N-1:0]  s_ready;
  logic          s_w0, s_w1;
  logic [NW-1:0] s_n0, s_n1;
  logic [DW-1:0] s_d0, s_d1;
  logic [3:0]    s_cnt;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_num_in(req_num_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out),
    .write0_out(write0_out), .write1_out(write1_out),
    .num_write0_out(num_write0_out), .num_write1_out(num_write1_out),
    .data_write0_out(data_write0_out), .data_write1_out(data_write1_out),
    .conflict_cnt_out(conflict_cnt_out)
  );

  regfile_wb_arbiter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_num_in(req_num_in), .req_data_in(req_data_in),
    .req_ready_out(s_ready),
    .write0_out(s_w0), .write1_out(s_w1),
    .num_write0_out(s_n0), .num_write1_out(s_n1),
    .data_write0_out(s_d0), .data_write1_out(s_d1),
    .conflict_cnt_out(s_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registered write-port image, pointer and conflict count
  int m_ptr, m_cnt, m_n0, m_n1, m_d0, m_d1;
  logic m_w0, m_w1;
  int p_g0, p_g1, p_n0, p_n1, p_d0, p_d1;
  logic p_f0, p_f1, p_conf;
  logic [N-1:0] p_ready;

  task automatic m_reset();
    m_ptr = 0; m_cnt = 0;
    m_w0 = 1'b0; m_w1 = 1'b0;
    m_n0 = 0; m_n1 = 0; m_d0 = 0; m_d1 = 0;
  endtask

  task automatic model_pick();
    wb_req_t r [N];
    int j;
    for (int k = 0; k < N; k++) begin
      r[k].valid = req_valid_in[k];
      r[k].num   = req_num_in[k*NW +: NW];
      r[k].data  = req_data_in[k*DW +: DW];
    end
    p_f0 = 1'b0; p_f1 = 1'b0; p_conf = 1'b0; p_g0 = 0; p_g1 = 0;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (r[j].valid) begin
        if (!p_f0) begin
          p_f0 = 1'b1; p_g0 = j;
        end else if (r[j].num == r[p_g0].num) begin
          p_conf = 1'b1;
        end else if (!p_f1) begin
          p_f1 = 1'b1; p_g1 = j;
        end
      end
    end
    p_ready = '0;
    if (p_f0) p_ready[p_g0] = 1'b1;
    if (p_f1) p_ready[p_g1] = 1'b1;
    p_n0 = int'(r[p_g0].num); p_d0 = int'(r[p_g0].data);
    p_n1 = int'(r[p_g1].num); p_d1 = int'(r[p_g1].data);
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      model_pick();
      if (rst) begin
        p_ready = '0; p_f0 = 1'b0; p_f1 = 1'b0; p_conf = 1'b0;
      end
      check("ready", 64'(req_ready_out), 64'(p_ready));
      check("write0", 64'(write0_out), 64'(m_w0));
      check("write1", 64'(write1_out), 64'(m_w1));
      check("num0", 64'(num_write0_out), 64'(m_n0));
      check("num1", 64'(num_write1_out), 64'(m_n1));
      check("data0", 64'(data_write0_out), 64'(m_d0));
      check("data1", 64'(data_write1_out), 64'(m_d1));
      check("conflict_cnt", 64'(conflict_cnt_out), 64'(m_cnt));
      check("conflict_cnt4", 64'(s_cnt), 64'((m_cnt > 15) ? 15 : m_cnt));
      if (write0_out && write1_out)
        check("distinct_idx", 64'(num_write0_out == num_write1_out), 64'(0));
      @(posedge clk);
      if (rst) begin
        m_reset();
      end else begin
        m_w0 = p_f0; m_w1 = p_f1;
        if (p_f0) begin m_n0 = p_n0; m_d0 = p_d0; end
        if (p_f1) begin m_n1 = p_n1; m_d1 = p_d1; end
        if (p_f1) m_ptr = (p_g1 + 1) % N;
        else if (p_f0) m_ptr = (p_g0 + 1) % N;
        if (p_conf && m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] v, input int n0, input int n1, input int n2,
                        input int d0, input int d1, input int d2);
    req_valid_in = v;
    req_num_in   = {NW'(n2), NW'(n1), NW'(n0)};
    req_data_in  = {DW'(d2), DW'(d1), DW'(d0)};
  endtask

  int gcnt [N];
  logic [2:0] rot_tbl [6];

  initial begin
    rot_tbl = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
    rst = 1'b1;
    set_in(3'b111, 1, 2, 3, 1, 2, 3);
    step();
    check("rst_ready", 64'(req_ready_out), 64'(0));
    check("rst_write0", 64'(write0_out), 64'(0));
    check("rst_cnt", 64'(conflict_cnt_out), 64'(0));
    step();
    rst = 1'b0;
    set_in(3'b011, 2, 5, 0, 'h1111, 'h2222, 0);
    #1;
    check("two_grant_ready", 64'(req_ready_out), 64'(3'b011));
    step();
    check("two_w0", 64'({write0_out, num_write0_out, data_write0_out}), 64'({1'b1, 3'd2, 16'h1111}));
    check("two_w1", 64'({write1_out, num_write1_out, data_write1_out}), 64'({1'b1, 3'd5, 16'h2222}));
    check("two_model_ptr", 64'(m_ptr), 64'(2));

    set_in(3'b100, 0, 0, 7, 0, 0, 'h7777);
    step();
    set_in(3'b111, 3, 3, 6, 'hAAAA, 'hBBBB, 'hCCCC);
    #1;
    check("conflict_ready", 64'(req_ready_out), 64'(3'b101));
    check("conflict_cnt_before", 64'(conflict_cnt_out), 64'(0));
    step();
    check("conflict_cnt_after", 64'(conflict_cnt_out), 64'(1));
    check("conflict_w0", 64'({write0_out, num_write0_out, data_write0_out}), 64'({1'b1, 3'd3, 16'hAAAA}));
    check("conflict_w1", 64'({write1_out, num_write1_out, data_write1_out}), 64'({1'b1, 3'd6, 16'hCCCC}));
    set_in(3'b010, 3, 3, 6, 'hAAAA, 'hBBBB, 'hCCCC);
    #1;
    check("deferred_ready", 64'(req_ready_out), 64'(3'b010));
    step();
    check("deferred_w0", 64'({write0_out, num_write0_out, data_write0_out}), 64'({1'b1, 3'd3, 16'hBBBB}));
    check("deferred_w1", 64'(write1_out), 64'(0));

    set_in(3'b100, 0, 0, 7, 0, 0, 'h7777);
    step();
    check("rot_model_ptr", 64'(m_ptr), 64'(0));
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(3'b111, 1, 2, 4, 'h100 + c, 'h200 + c, 'h400 + c);
      #1;
      check("rot_ready", 64'(req_ready_out), 64'(rot_tbl[c]));
      for (int k = 0; k < N; k++) gcnt[k] += int'(req_ready_out[k]);
      step();
    end
    for (int k = 0; k < N; k++) check("rot_grants", 64'(gcnt[k]), 64'(4));

    set_in(3'b000, 0, 0, 0, 0, 0, 0);
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_writes", 64'({write0_out, write1_out, req_ready_out}), 64'(0));
    end
    check("idle_cnt", 64'(conflict_cnt_out), 64'(1));
    check("idle_model_ptr", 64'(m_ptr), 64'(0));

    set_in(3'b001, 1, 0, 0, 'h5555, 0, 0);
    #1;
    check("rstmid_ready", 64'(req_ready_out), 64'(3'b001));
    rst = 1'b1;
    #1;
    check("rstmid_ready_rst", 64'(req_ready_out), 64'(0));
    step();
    rst = 1'b0;
    set_in(3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    check("rstmid_outs", 64'({write0_out, write1_out, num_write0_out, data_write0_out}), 64'(0));
    check("rstmid_cnt", 64'(conflict_cnt_out), 64'(0));
    step();
    check("rstmid_after_release", 64'({write0_out, write1_out}), 64'(0));

    set_in(3'b011, 4, 4, 0, 'h1, 'h2, 0);
    repeat (14) step();
    check("sat_below", 64'(s_cnt), 64'(14));
    repeat (5) step();
    check("sat_hold", 64'(s_cnt), 64'(15));
    check("sat_wide", 64'(conflict_cnt_out), 64'(19));

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             int'($urandom), int'($urandom), int'($urandom));
      step();
    end
    rst = 1'b0;
    set_in(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
